// File: rtl/lbm_stream_pkg.sv
// Shared definitions for the lattice-Boltzmann streaming blocks: default
// population geometry and the frame reader state encoding.
package lbm_stream_pkg;

  localparam int unsigned LBM_DATA_WIDTH = 16;
  localparam int unsigned LBM_Q          = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } stream_state_t;

  // Output buffer depth needed to keep one beat per cycle for a given BRAM latency.
  function automatic int unsigned stream_fifo_depth(input int unsigned rd_latency);
    return rd_latency + 2;
  endfunction

endpackage

// File: rtl/lattice_stream_reader_fifo.sv
// stream_out_fifo: small synchronous FIFO holding {last, data} beats in front
// of the AXI-Stream output. Head entry is presented directly on rd_data.
module stream_out_fifo #(
  parameter  int unsigned DEPTH = 3,
  parameter  int unsigned WIDTH = 145,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             not_empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_nxt;
  logic             push;
  logic             pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign push    = wr_en && (count != CNT_W'(DEPTH));
  assign pop     = rd_en && not_empty;
  assign rd_data = mem[rd_ptr];

  // Next occupancy from simultaneous push/pop.
  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers; reset flushes the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      not_empty <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count     <= count_nxt;
      not_empty <= (count_nxt != '0);
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/lattice_stream_reader.sv
// lattice_stream_reader: reads one frame of DEPTH pixel words from a BRAM and
// emits them as an AXI-Stream, one beat per pixel, tlast on the final pixel.
// Reads are only issued while the output buffer has room for every read in
// flight, so m_tready back-pressure never loses data.
// Optional feature: define LATTICE_STREAM_SOF_EN to add m_tuser (start of frame).
// RD_LATENCY must be 1 or 2; 2**ADDR_WIDTH must cover DEPTH.
module lattice_stream_reader
  import lbm_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = LBM_DATA_WIDTH,
  parameter int unsigned Q          = LBM_Q,
  parameter int unsigned DEPTH      = 2500,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_ready,
  output logic                        rd_en,
  output logic [ADDR_WIDTH-1:0]       rd_addr,
  input  logic [Q*DATA_WIDTH-1:0]     rd_data,
  output logic [Q*DATA_WIDTH-1:0]     m_tdata,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic                        m_tlast,
`ifdef LATTICE_STREAM_SOF_EN
  output logic                        m_tuser,
`endif
  output logic [Q*DATA_WIDTH/8-1:0]   m_tkeep,
  output logic                        busy,
  output logic                        frame_done
);

  localparam int unsigned BUS_W      = Q * DATA_WIDTH;
  localparam int unsigned FIFO_DEPTH = stream_fifo_depth(RD_LATENCY);
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W      = CNT_W + 1;
  localparam int unsigned IDX_W      = ADDR_WIDTH + 1;

  stream_state_t state;
  stream_state_t state_nxt;

  logic [IDX_W-1:0]      index;
  logic [IDX_W-1:0]      index_nxt;
  logic                  rd_en_nxt;
  logic [ADDR_WIDTH-1:0] rd_addr_nxt;
  logic                  rd_last;
  logic                  rd_last_nxt;
  logic                  busy_nxt;
  logic                  frame_done_nxt;

  logic [RD_LATENCY-1:0] pipe_vld;
  logic [RD_LATENCY-1:0] pipe_last;

  logic [BUS_W:0]        fifo_head;
  logic                  fifo_valid;
  logic [CNT_W-1:0]      fifo_count;
  logic                  pop;
  logic [OCC_W-1:0]      occ;
  logic                  room;

  assign pop      = m_tvalid && m_tready;
  assign m_tvalid = fifo_valid;
  assign m_tdata  = fifo_head[BUS_W-1:0];
  assign m_tlast  = fifo_valid && fifo_head[BUS_W];
  assign m_tkeep  = '1;

  // Buffered beats plus reads still travelling through the BRAM.
  always_comb begin
    occ = OCC_W'(fifo_count) + OCC_W'(rd_en);
    for (int i = 0; i < int'(RD_LATENCY); i++) begin
      occ = occ + OCC_W'(pipe_vld[i]);
    end
    room = (occ - OCC_W'(pop)) < OCC_W'(FIFO_DEPTH);
  end

  // Frame sequencing and read issue; outputs are registered from *_nxt.
  always_comb begin
    state_nxt      = state;
    index_nxt      = index;
    rd_en_nxt      = 1'b0;
    rd_addr_nxt    = rd_addr;
    rd_last_nxt    = 1'b0;
    frame_done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (frame_ready) begin
          state_nxt   = STREAM;
          rd_en_nxt   = 1'b1;
          rd_addr_nxt = '0;
          rd_last_nxt = (DEPTH == 1);
          index_nxt   = IDX_W'(1);
        end
      end
      STREAM: begin
        if (rd_en && rd_last) begin
          state_nxt = DRAIN;
        end else if ((index < IDX_W'(DEPTH)) && room) begin
          rd_en_nxt   = 1'b1;
          rd_addr_nxt = ADDR_WIDTH'(index);
          rd_last_nxt = (index == IDX_W'(DEPTH - 1));
          index_nxt   = index + IDX_W'(1);
        end
      end
      DRAIN: begin
        if (pop && m_tlast) begin
          state_nxt      = IDLE;
          frame_done_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // State and registered control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      index      <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      rd_last    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      index      <= index_nxt;
      rd_en      <= rd_en_nxt;
      rd_addr    <= rd_addr_nxt;
      rd_last    <= rd_last_nxt;
      busy       <= busy_nxt;
      frame_done <= frame_done_nxt;
    end
  end

  // Track reads through the BRAM so data is captured exactly RD_LATENCY later;
  // clearing on reset drops any data still returning from an abandoned frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld  <= '0;
      pipe_last <= '0;
    end else begin
      pipe_vld[0]  <= rd_en;
      pipe_last[0] <= rd_en && rd_last;
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
    end
  end

  stream_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BUS_W + 1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (pipe_vld[RD_LATENCY-1]),
    .wr_data   ({pipe_last[RD_LATENCY-1], rd_data}),
    .rd_en     (pop),
    .rd_data   (fifo_head),
    .not_empty (fifo_valid),
    .count     (fifo_count)
  );

`ifdef LATTICE_STREAM_SOF_EN
  logic sof_pending;

  // Beat 0 is the first pop after a frame starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      sof_pending <= 1'b0;
    end else if ((state == IDLE) && frame_ready) begin
      sof_pending <= 1'b1;
    end else if (pop) begin
      sof_pending <= 1'b0;
    end
  end

  assign m_tuser = m_tvalid && sof_pending;
`endif

endmodule
